uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx_mmio.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  localparam logic [2:0] OFF_DATA   = 3'h0;
  localparam logic [2:0] OFF_STATUS = 3'h4;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;

  // The STATUS count field is four bits wide; deeper FIFOs report 15.
  function automatic logic [3:0] sat_count4(input logic [31:0] v);
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS register window, transmit FIFO, serializer FSM.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] io_rdata,
  output logic        io_hit,
  output logic        uart_tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic [31:0]       offset;
  logic              wr_en;
  logic              rd_en;
  logic              sel_status;
  logic              push;
  logic              overflow;
  logic              fifo_pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              ovf;
  logic [31:0]       status_word;

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              tx;
  logic              unused_wdata;

  assign unused_wdata = ^mem_wdata[31:8];

  assign offset     = mem_addr - BASE_ADDR;
  assign io_hit     = (offset < 32'd8);
  assign sel_status = (offset[2:0] & OFF_STATUS) != '0;
  assign wr_en      = !rst && io_hit && (mem_wmask != '0);
  assign rd_en      = !rst && io_hit && mem_rstrb;
  assign push       = wr_en && !sel_status && mem_wmask[0];
  assign overflow   = push && fifo_full && !fifo_pop;

  // The FSM consumes a byte on the same edge it leaves IDLE or finishes a stop bit.
  assign fifo_pop = !fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && (baud == '0)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (mem_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_COUNT_LSB +: 4] = sat_count4(32'(fifo_count));
    status_word[STAT_OVF]   = ovf;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_BUSY]  = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_rdata <= '0;
      ovf      <= 1'b0;
    end else begin
      if (rd_en) begin
        io_rdata <= sel_status ? status_word : '0;
      end
      // A same-cycle overflow outranks the clear-on-read.
      if (overflow) begin
        ovf <= 1'b1;
      end else if (rd_en && sel_status) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shreg <= fifo_rdata;
            baud  <= BAUD_RELOAD;
            tx    <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (baud != '0) begin
            baud <= baud - 1'b1;
          end else begin
            baud    <= BAUD_RELOAD;
            bit_cnt <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud != '0) begin
            baud <= baud - 1'b1;
          end else begin
            baud <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
        ST_STOP: begin
          if (baud != '0) begin
            baud <= baud - 1'b1;
          end else if (!fifo_empty) begin
            shreg <= fifo_rdata;
            baud  <= BAUD_RELOAD;
            tx    <= 1'b0;
            state <= ST_START;
          end else begin
            tx    <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart_tx = tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed and randomized checks of uart_tx_mmio against a frame-level reference model.
module tb_uart_tx_mmio;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] io_rdata;
  logic        io_hit;
  logic        uart_tx;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .io_rdata  (io_rdata),
    .io_hit    (io_hit),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int unsigned rx_start_q[$];
  int          framing = 0;
  logic [7:0]  bdata [16];
  logic        hit_seen;

  // Line receiver: samples each bit mid-period and records byte plus start-bit cycle.
  bit          mon_active = 1'b0;
  int unsigned mon_start;
  logic [7:0]  mon_byte;
  always @(posedge clk) begin
    int unsigned k;
    #2;
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_start  = cyc;
      end
    end else begin
      k = cyc - mon_start;
      if (k == 2 && uart_tx !== 1'b0) begin
        framing++;
        mon_active = 1'b0;
      end else if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) begin
        mon_byte[(k - 6) / 4] = uart_tx;
      end else if (k == 38) begin
        if (uart_tx !== 1'b1) framing++;
        else begin
          rx_q.push_back(mon_byte);
          rx_start_q.push_back(mon_start);
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input bit ovf, input bit emp,
                                             input bit full, input bit busy);
    int c;
    c = (cnt > 15) ? 15 : cnt;
    return 32'(c * 16 + ovf * 8 + emp * 4 + full * 2 + busy);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    mem_addr  = addr;
    mem_wdata = data;
    mem_wmask = mask;
    #1 hit_seen = io_hit;
    step();
    mem_wmask = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    mem_addr  = addr;
    mem_rstrb = 1'b1;
    #1 hit_seen = io_hit;
    step();
    mem_rstrb = 1'b0;
    data = io_rdata;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(rx_q.size()), 32'(n));
  endtask

  // Compares received bytes with the model; optionally checks first-start latency and contiguity.
  task automatic compare_rx(input string tag, input int unsigned first_start, input bit contiguous);
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) begin
      check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      if (contiguous && i > 0)
        check({tag, "_gap"}, rx_start_q[i] - rx_start_q[i-1], 32'(10 * CPB));
    end
    if (first_start != 0 && rx_start_q.size() > 0)
      check({tag, "_latency"}, rx_start_q[0], first_start);
    exp_q.delete();
    rx_q.delete();
    rx_start_q.delete();
  endtask

  // Writes bdata[0..n-1] starting from an idle transmitter; the whole burst fits inside the first frame.
  task automatic run_burst(input string tag, input int n, input int max_gap);
    int unsigned p = 0;
    bit          busy_m = 1'b0;
    bit          ovf_m = 1'b0;
    int          qn = 0;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  mask;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, max_gap)) step();
      wd = $urandom();
      wd[7:0] = bdata[i];
      mask = 4'($urandom_range(0, 7) * 2 + 1);
      bus_write(BASE, wd, mask);
      if (i == 0) p = cyc;
      if (!busy_m) begin
        busy_m = 1'b1;
        exp_q.push_back(bdata[i]);
      end else if (qn < DEPTH) begin
        qn++;
        exp_q.push_back(bdata[i]);
      end else begin
        ovf_m = 1'b1;
      end
    end
    step();
    bus_read(BASE + 4, rd);
    check({tag, "_status1"}, rd, exp_status(qn, ovf_m, qn == 0, qn == DEPTH, 1'b1));
    bus_read(BASE + 4, rd);
    check({tag, "_status2"}, rd, exp_status(qn, 1'b0, qn == 0, qn == DEPTH, 1'b1));
    wait_rx({tag, "_wait"}, exp_q.size(), (exp_q.size() + 1) * 10 * CPB + 50);
    compare_rx(tag, p + 1, 1'b1);
    repeat (4) step();
  endtask

  initial begin
    logic [31:0] rd;
    int unsigned p;
    int          busy_cnt;
    int          low_cnt;
    logic [7:0]  b;
    logic        exp_tx;

    rst = 1'b1;
    mem_addr = BASE;
    mem_wdata = '0;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
    repeat (3) step();
    check("reset_tx", 32'(uart_tx), 32'd1);
    check("reset_rdata", io_rdata, 32'd0);
    rst = 1'b0;
    step();
    bus_read(BASE + 4, rd);
    check("reset_status", rd, 32'h04);

    // Single 0x55 frame: exact waveform and BUSY duration.
    b = 8'h55;
    bus_write(BASE, 32'h0000_0055, 4'h1);
    p = cyc;
    check("push_tx_still_idle", 32'(uart_tx), 32'd1);
    exp_q.push_back(b);
    mem_addr  = BASE + 4;
    mem_rstrb = 1'b1;
    busy_cnt  = 0;
    for (int j = 1; j <= 44; j++) begin
      step();
      if (j <= 4) exp_tx = 1'b0;
      else if (j <= 36) exp_tx = b[(j - 5) / 4];
      else exp_tx = 1'b1;
      check("wave_0x55", 32'(uart_tx), 32'(exp_tx));
      busy_cnt += int'(io_rdata[0]);
    end
    mem_rstrb = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'(10 * CPB));
    wait_rx("wave_wait", 1, 20);
    compare_rx("wave", p + 1, 1'b0);
    repeat (4) step();

    // Back-to-back pair with a mid-frame STATUS read.
    bdata[0] = 8'hA5;
    bdata[1] = 8'h3C;
    run_burst("pair", 2, 0);

    // Ten writes into an eight-deep FIFO: one dropped, sticky OVF cleared by read.
    for (int i = 0; i < 10; i++) bdata[i] = 8'($urandom_range(0, 255));
    run_burst("ovf10", 10, 0);

    // Push on the pop cycle with the FIFO full.
    for (int i = 0; i < 10; i++) bdata[i] = 8'($urandom_range(0, 255));
    bus_write(BASE, {24'h0, bdata[0]}, 4'h1);
    p = cyc;
    for (int i = 1; i < 9; i++) bus_write(BASE, {24'h0, bdata[i]}, 4'h1);
    for (int i = 0; i < 10; i++) exp_q.push_back(bdata[i]);
    while (cyc < p + 10 * CPB) step();
    bus_write(BASE, {24'h0, bdata[9]}, 4'h1);
    bus_read(BASE + 4, rd);
    check("fullpop_status", rd, exp_status(DEPTH, 1'b0, 1'b0, 1'b1, 1'b1));
    wait_rx("fullpop_wait", 10, 11 * 10 * CPB + 50);
    compare_rx("fullpop", p + 1, 1'b1);
    repeat (4) step();

    // Reset in the middle of data bit 3, with a second byte queued and a write during reset.
    bus_write(BASE, 32'h0000_00F0, 4'h1);
    p = cyc;
    bus_write(BASE, 32'h0000_0081, 4'h1);
    while (cyc < p + 18) step();
    check("pre_reset_bit3", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    bus_write(BASE, 32'h0000_0077, 4'h1);
    rst = 1'b0;
    check("abort_tx_high", 32'(uart_tx), 32'd1);
    bus_read(BASE + 4, rd);
    check("abort_status", rd, 32'h04);
    low_cnt = 0;
    for (int j = 0; j < 100; j++) begin
      step();
      if (uart_tx !== 1'b1) low_cnt++;
    end
    check("abort_line_idle", 32'(low_cnt), 32'd0);
    check("abort_no_frames", 32'(rx_q.size()), 32'd0);
    rx_q.delete();
    rx_start_q.delete();

    // Ignored accesses and address decode edges.
    bus_write(BASE + 4, 32'h0000_00FF, 4'hF);
    check("hit_status", 32'(hit_seen), 32'd1);
    bus_write(BASE, 32'h0000_00AA, 4'b0010);
    bus_write(BASE + 8, 32'h0000_00BB, 4'hF);
    check("hit_base8", 32'(hit_seen), 32'd0);
    mem_addr = BASE + 7;
    #1 check("hit_base7", 32'(io_hit), 32'd1);
    mem_addr = BASE - 1;
    #1 check("hit_below", 32'(io_hit), 32'd0);
    bus_read(BASE + 4, rd);
    check("ignored_status", rd, 32'h04);
    bus_read(BASE + 8, rd);
    check("outside_read_holds", rd, 32'h04);
    bus_read(BASE, rd);
    check("data_read_zero", rd, 32'h0);
    repeat (60) step();
    check("ignored_no_frames", 32'(rx_q.size()), 32'd0);
    rx_q.delete();
    rx_start_q.delete();

    // Randomized bursts with random spacing, data and write masks.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) bdata[i] = 8'($urandom_range(0, 255));
      run_burst("rand", n, 2);
    end

    check("framing_errors", 32'(framing), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
